// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline MEM stage.
//   PIPE_DATA_W  default datapath/address width
//   PIPE_RD_W    default destination register index width
//   mem_state_t  MEM stage handshake FSM states (IDLE, WAIT)
package pipe_pkg;

  localparam int PIPE_DATA_W = 8;
  localparam int PIPE_RD_W   = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: MEM stage sitting after the EX/MEM register.
// ALU-only instructions pass into the MEM/WB register with one cycle of
// latency. Loads and stores run a req/ack handshake against a
// variable-latency data memory, stalling upstream until ack or timeout.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   in_valid/in_rd/in_alu/...   EX/MEM slot (in_alu is the address for ld/st)
//   stall                       combinational hold for EX/MEM and earlier stages
//   mem_req/mem_we/mem_addr/
//   mem_wdata                   registered memory request bundle
//   mem_ack/mem_rdata           1-cycle completion pulse and read data
//   out_valid/out_rd/out_data/
//   out_reg_wr                  MEM/WB register
//   err                         sticky error (ld+st conflict or memory timeout)
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int RD_W    = PIPE_RD_W,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_alu,
  input  logic              in_reg_wr,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [DATA_W-1:0] in_st_data,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_reg_wr,
  output logic              err
);

  // Last WAIT cycle index: counter starts at 0 in the first WAIT cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

  mem_state_t      state;
  logic [TO_W-1:0] cnt;
  logic [RD_W-1:0] cap_rd;
  logic            cap_reg_wr;
  logic            cap_load;
  logic            mem_op;
  logic            to_hit;

  assign mem_op = in_mem_rd | in_mem_wr;
  assign to_hit = (cnt == TO_LAST);

  // Upstream hold: a new mem op stalls at once; WAIT releases on ack or timeout.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && mem_op) stall = 1'b1;
        else                    stall = 1'b0;
      end
      WAIT: begin
        if (mem_ack || to_hit) stall = 1'b0;
        else                   stall = 1'b1;
      end
      default: stall = 1'b0;
    endcase
  end

  // Handshake FSM plus MEM/WB register and memory request bundle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_rd     <= '0;
      cap_reg_wr <= 1'b0;
      cap_load   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      out_valid  <= 1'b0;
      out_rd     <= '0;
      out_data   <= '0;
      out_reg_wr <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && mem_op) begin
            // mem_addr/mem_wdata double as the captured address and store data.
            cap_rd     <= in_rd;
            cap_reg_wr <= in_reg_wr;
            cap_load   <= in_mem_rd;
            mem_req    <= 1'b1;
            mem_we     <= in_mem_wr & ~in_mem_rd;
            mem_addr   <= in_alu;
            mem_wdata  <= in_st_data;
            out_valid  <= 1'b0;
            cnt        <= '0;
            state      <= WAIT;
            // Conflicting ld+st runs as a load but is flagged.
            if (in_mem_rd && in_mem_wr) err <= 1'b1;
            else                        err <= err;
          end else if (in_valid) begin
            out_valid  <= 1'b1;
            out_rd     <= in_rd;
            out_data   <= in_alu;
            out_reg_wr <= in_reg_wr;
          end else begin
            out_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            // Ack beats timeout when both land on the same cycle.
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
            out_rd    <= cap_rd;
            state     <= IDLE;
            if (cap_load) begin
              out_data   <= mem_rdata;
              out_reg_wr <= cap_reg_wr;
            end else begin
              out_data   <= mem_addr;
              out_reg_wr <= 1'b0;
            end
          end else if (to_hit) begin
            mem_req    <= 1'b0;
            out_valid  <= 1'b1;
            out_rd     <= cap_rd;
            out_data   <= '0;
            out_reg_wr <= 1'b0;
            err        <= 1'b1;
            state      <= IDLE;
          end else begin
            out_valid <= 1'b0;
            cnt       <= cnt + CNT_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb_pipe_mem_stage: directed bench for pipe_mem_stage. Expected MEM/WB
// results are queued per instruction from the instruction's meaning and the
// memory's answer; a negedge process compares every valid output slot,
// the request bundle and err, and counts stall cycles per instruction.
module tb_pipe_mem_stage;
  import pipe_pkg::*;

  localparam int DW  = 8;
  localparam int RW  = 2;
  localparam int TMO = 15;
  localparam int TW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_reg_wr, in_mem_rd, in_mem_wr;
  logic [RW-1:0] in_rd;
  logic [DW-1:0] in_alu, in_st_data;
  logic          stall, mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          out_valid, out_reg_wr, err;
  logic [RW-1:0] out_rd;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  pipe_mem_stage #(.DATA_W(DW), .RD_W(RW), .TIMEOUT(TMO), .TO_W(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_rd(in_rd), .in_alu(in_alu), .in_reg_wr(in_reg_wr),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_st_data(in_st_data),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data),
    .out_reg_wr(out_reg_wr), .err(err)
  );

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          reg_wr;
    logic          chk_rd;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur_e;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            stall_cnt = 0;
  logic          exp_err = 1'b0;
  logic          in_wait = 1'b0;
  logic          exp_we = 1'b0;
  logic [DW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the expected-result queue and request model.
  always @(negedge clk) begin
    if (!reset) begin
      if (stall) stall_cnt++;
      chk("err", {31'd0, err}, {31'd0, exp_err});
      chk("mem_req", {31'd0, mem_req}, {31'd0, in_wait});
      if (in_wait) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, exp_addr});
        chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, exp_wdata});
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_slot: got out_valid=1, expected no result at %0t", $time);
        end else begin
          cur_e = exp_q.pop_front();
          if (cur_e.chk_rd) chk("out_rd", {30'd0, out_rd}, {30'd0, cur_e.rd});
          chk("out_data", {24'd0, out_data}, {24'd0, cur_e.data});
          chk("out_reg_wr", {31'd0, out_reg_wr}, {31'd0, cur_e.reg_wr});
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid  = 1'b0;
    in_mem_rd = 1'b0;
    in_mem_wr = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one instruction and play the memory; ack_wait = WAIT cycles
  // before the ack cycle, or -1 for a memory that never answers.
  task automatic issue(input logic [RW-1:0] rd, input logic [DW-1:0] alu,
                       input logic rw, input logic mrd, input logic mwr,
                       input logic [DW-1:0] sd, input int ack_wait,
                       input logic [DW-1:0] rdata);
    int   st0;
    int   exp_st;
    exp_t e;
    logic acked;
    acked      = (ack_wait >= 0) && (ack_wait < TMO);
    in_valid   = 1'b1;
    in_rd      = rd;
    in_alu     = alu;
    in_reg_wr  = rw;
    in_mem_rd  = mrd;
    in_mem_wr  = mwr;
    in_st_data = sd;
    mem_ack    = 1'b0;
    st0        = stall_cnt;
    if (!(mrd | mwr)) begin
      e = '{rd, alu, rw, 1'b1};
      exp_q.push_back(e);
      exp_st = 0;
      @(posedge clk);
      #1;
    end else begin
      if (!acked)  e = '{rd, {DW{1'b0}}, 1'b0, 1'b0};
      else if (mrd) e = '{rd, rdata, rw, 1'b1};
      else          e = '{rd, alu, 1'b0, 1'b1};
      exp_q.push_back(e);
      exp_st    = acked ? ack_wait + 1 : TMO;
      exp_we    = mwr & ~mrd;
      exp_addr  = alu;
      exp_wdata = sd;
      @(posedge clk);
      #1;
      in_wait = 1'b1;
      if (mrd && mwr) exp_err = 1'b1;
      for (int w = 1; w <= TMO; w++) begin
        if (w == ack_wait + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
          @(posedge clk);
          #1;
          mem_ack   = 1'b0;
          mem_rdata = 8'hEE;
          in_wait   = 1'b0;
          break;
        end
        @(posedge clk);
        #1;
        if (w == TMO) begin
          in_wait = 1'b0;
          exp_err = 1'b1;
        end
      end
    end
    chk("stall_cycles", stall_cnt - st0, exp_st);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_alu = '0; in_reg_wr = 1'b0;
    in_mem_rd = 1'b0; in_mem_wr = 1'b0; in_st_data = '0;
    mem_ack = 1'b0; mem_rdata = 8'hEE;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    idle(1);

    // 1: ALU op
    issue(2'd2, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, -1, 8'h00);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_rd", {30'd0, out_rd}, 32'd2);
    chk("t1_data", {24'd0, out_data}, 32'h5A);
    idle(2);

    // 2: load, stall high 4 cycles
    issue(2'd1, 8'h10, 1'b1, 1'b1, 1'b0, 8'h00, 3, 8'hC3);
    chk("t2_data", {24'd0, out_data}, 32'hC3);
    chk("t2_reg_wr", {31'd0, out_reg_wr}, 32'd1);
    idle(1);

    // 3: store, ack after 1 cycle
    issue(2'd3, 8'h20, 1'b1, 1'b0, 1'b1, 8'h77, 1, 8'h00);
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_reg_wr", {31'd0, out_reg_wr}, 32'd0);
    chk("t3_data", {24'd0, out_data}, 32'h20);
    idle(1);

    // ack on the timeout cycle wins without error
    issue(2'd2, 8'h40, 1'b1, 1'b1, 1'b0, 8'h00, 14, 8'h3C);
    chk("tack_last_data", {24'd0, out_data}, 32'h3C);
    chk("tack_last_err", {31'd0, err}, 32'd0);
    idle(1);

    // 4: load never acked -> timeout, then a normal ALU op
    issue(2'd0, 8'h30, 1'b1, 1'b1, 1'b0, 8'h00, -1, 8'h00);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_reg_wr", {31'd0, out_reg_wr}, 32'd0);
    chk("t4_data", {24'd0, out_data}, 32'd0);
    idle(1);
    issue(2'd1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, -1, 8'h00);
    chk("t4_alu_data", {24'd0, out_data}, 32'hA5);
    idle(1);

    // 5: reset in the 2nd WAIT cycle, late ack ignored
    in_valid = 1'b1; in_rd = 2'd3; in_alu = 8'h60; in_reg_wr = 1'b1;
    in_mem_rd = 1'b1; in_mem_wr = 1'b0;
    exp_we = 1'b0; exp_addr = 8'h60; exp_wdata = in_st_data;
    @(posedge clk);
    #1;
    in_wait = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    in_wait = 1'b0; exp_err = 1'b0; exp_q.delete();
    in_valid = 1'b0; in_mem_rd = 1'b0;
    chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_out_data", {24'd0, out_data}, 32'd0);
    chk("t5_out_rd", {30'd0, out_rd}, 32'd0);
    chk("t5_out_reg_wr", {31'd0, out_reg_wr}, 32'd0);
    chk("t5_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'hBB;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    chk("t5_late_ack_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_late_ack_req", {31'd0, mem_req}, 32'd0);
    idle(1);

    // 6: ALU, load with immediate ack, ALU back to back
    issue(2'd0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, -1, 8'h00);
    issue(2'd1, 8'h12, 1'b1, 1'b1, 1'b0, 8'h00, 0, 8'hD4);
    chk("t6_load_data", {24'd0, out_data}, 32'hD4);
    issue(2'd2, 8'h13, 1'b0, 1'b0, 1'b0, 8'h00, -1, 8'h00);
    chk("t6_alu_data", {24'd0, out_data}, 32'h13);
    idle(2);

    // ld+st together: runs as a load, raises err
    issue(2'd3, 8'h50, 1'b1, 1'b1, 1'b1, 8'h99, 0, 8'h66);
    chk("tconf_data", {24'd0, out_data}, 32'h66);
    chk("tconf_err", {31'd0, err}, 32'd1);
    idle(2);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
